// File: rtl/keyboard_event_queue_if.sv
// Key-event stream from the scancode queue to the CPU side.
// [9] break, [8] extended, [7:0] scancode.
interface keyboard_event_queue_if;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/keyboard_event_queue.sv
// Folds PS/2 set-2 E0/F0 prefixes into single key events and queues them in a
// first-word-fall-through FIFO. Stale prefixes are dropped after TIMEOUT cycles.
module keyboard_event_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                kb_data,
  input  logic                      kb_valid,
  keyboard_event_queue_if.master    ev,
  output logic [$clog2(DEPTH):0]    ev_count,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  logic          s1_q, s2_q, prev_q;
  logic          strobe;
  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push;
  logic [9:0]    push_data;
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, wr_en;
  logic          is_e0, is_f0;

  // kb_valid crosses from the ps2_clk domain; kb_data is held, so it is used unsynchronized.
  assign strobe = s2_q & ~prev_q;
  assign is_e0  = (kb_data == 8'hE0);
  assign is_f0  = (kb_data == 8'hF0);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    push_data = '0;
    if (strobe) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (is_e0)      state_d = StExt;
          else if (is_f0) state_d = StBrk;
          else begin
            push      = 1'b1;
            push_data = {2'b00, kb_data};
          end
        end
        StExt: begin
          if (is_f0)      state_d = StExtBrk;
          else if (is_e0) state_d = StExt;
          else begin
            push      = 1'b1;
            push_data = {2'b01, kb_data};
            state_d   = StIdle;
          end
        end
        StBrk: begin
          if (is_e0)      state_d = StExt;
          else if (is_f0) state_d = StBrk;
          else begin
            push      = 1'b1;
            push_data = {2'b10, kb_data};
            state_d   = StIdle;
          end
        end
        StExtBrk: begin
          if (is_e0)      state_d = StExt;
          else if (is_f0) state_d = StExtBrk;
          else begin
            push      = 1'b1;
            push_data = {2'b11, kb_data};
            state_d   = StIdle;
          end
        end
      endcase
    end else if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      state_d = StIdle;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);
  assign pop   = ~empty & ev.ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;
    if (push & full & ~pop) ovf_d = 1'b1;
  end

  assign ev.ev_valid = ~empty;
  assign ev.ev_data  = empty ? '0 : mem_q[rptr_q];
  assign ev_count    = count_q;
  assign overflow    = ovf_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= StIdle;
      tmo_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= kb_valid;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      tmo_q   <= tmo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Self-checking bench: scancode vector table plus hand-written latency, overflow,
// timeout and reset sequences, with an expected-event queue as scoreboard.
module tb_keyboard_event_queue;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic                   clk      = 1'b0;
  logic                   rst_n    = 1'b0;
  logic [7:0]             kb_data  = 8'h00;
  logic                   kb_valid = 1'b0;
  logic                   clr_ovf  = 1'b0;
  logic [$clog2(DEPTH):0] ev_count;
  logic                   overflow;

  keyboard_event_queue_if ev_if ();

  keyboard_event_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kb_data  (kb_data),
    .kb_valid (kb_valid),
    .ev       (ev_if),
    .ev_count (ev_count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         push;
    logic [9:0] ev;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  vec_t       vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising edges of kb_valid end up 6 cycles apart; the event lands before return.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    kb_data  = b;
    kb_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 kb_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2 * DEPTH + 4) begin
      guard++;
      @(negedge clk);
      check({name, " valid"}, 32'(ev_if.ev_valid), 32'd1);
      if (!ev_if.ev_valid) begin
        exp_q.delete();
        break;
      end
      check({name, " data"}, 32'(ev_if.ev_data), 32'(exp_q.pop_front()));
      ev_if.ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_if.ev_ready = 1'b0;
    end
    @(negedge clk);
    check({name, " empty"}, 32'(ev_if.ev_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'h1C, 1'b1, 10'h21C});
    vecs.push_back('{8'hE0, 1'b0, 10'h000});
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'h74, 1'b1, 10'h374});
    vecs.push_back('{8'hE0, 1'b0, 10'h000});
    vecs.push_back('{8'h74, 1'b1, 10'h174});
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'hE0, 1'b0, 10'h000});
    vecs.push_back('{8'h75, 1'b1, 10'h175});
    vecs.push_back('{8'hE0, 1'b0, 10'h000});
    vecs.push_back('{8'hE0, 1'b0, 10'h000});
    vecs.push_back('{8'h12, 1'b1, 10'h112});
    vecs.push_back('{8'hE1, 1'b1, 10'h0E1});
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'h12, 1'b1, 10'h212});
    vecs.push_back('{8'hE0, 1'b0, 10'h000});
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'hF0, 1'b0, 10'h000});
    vecs.push_back('{8'h12, 1'b1, 10'h312});

    ev_if.ev_ready = 1'b0;
    idle(2);
    @(negedge clk);
    check("reset valid", 32'(ev_if.ev_valid), 32'd0);
    check("reset count", 32'(ev_count), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);
    check("reset data", 32'(ev_if.ev_data), 32'd0);
    rst_n = 1'b1;

    // Latency: sampled at edge N, event visible after edge N+2.
    @(negedge clk);
    kb_data  = 8'h1C;
    kb_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("lat n+1 valid", 32'(ev_if.ev_valid), 32'd0);
    @(posedge clk);
    #1 check("lat n+2 valid", 32'(ev_if.ev_valid), 32'd1);
    check("lat data", 32'(ev_if.ev_data), 32'h01C);
    check("lat count", 32'(ev_count), 32'd1);
    idle(4);
    check("held valid count", 32'(ev_count), 32'd1);
    kb_valid = 1'b0;
    idle(3);
    exp_q.push_back(10'h01C);
    drain("make");

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].b);
      if (vecs[i].push) exp_q.push_back(vecs[i].ev);
      check($sformatf("vec%0d count", i), 32'(ev_count), 32'(exp_q.size()));
    end
    check("table ovf", 32'(overflow), 32'd0);
    drain("table");

    // Overflow: ninth make code is dropped.
    for (int k = 0; k < 9; k++) begin
      send_byte(8'h10 + 8'(k));
      if (k < 8) exp_q.push_back(10'h010 + 10'(k));
    end
    @(negedge clk);
    check("full count", 32'(ev_count), 32'd8);
    check("full ovf", 32'(overflow), 32'd1);
    check("full head", 32'(ev_if.ev_data), 32'h010);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    check("clr ovf", 32'(overflow), 32'd0);

    // Push and pop land on the same edge while full.
    @(negedge clk);
    kb_data  = 8'h20;
    kb_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 ev_if.ev_ready = 1'b1;
    @(posedge clk);
    #1 ev_if.ev_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(10'h020);
    check("pushpop count", 32'(ev_count), 32'd8);
    check("pushpop ovf", 32'(overflow), 32'd0);
    check("pushpop head", 32'(ev_if.ev_data), 32'h011);
    kb_valid = 1'b0;
    idle(3);
    drain("full");

    // Prefix timeout drops the pending break.
    send_byte(8'hF0);
    idle(20);
    send_byte(8'h1C);
    exp_q.push_back(10'h01C);
    check("tmo count", 32'(ev_count), 32'd1);
    drain("tmo");
    send_byte(8'hF0);
    idle(4);
    send_byte(8'h1C);
    exp_q.push_back(10'h21C);
    drain("no tmo");

    // Reset mid-stream with a pending E0 and two queued events.
    send_byte(8'h1C);
    send_byte(8'h2C);
    check("pre-rst count", 32'(ev_count), 32'd2);
    send_byte(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst count", 32'(ev_count), 32'd0);
    check("rst data", 32'(ev_if.ev_data), 32'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h1C);
    exp_q.push_back(10'h01C);
    check("post-rst count", 32'(ev_count), 32'd1);
    drain("post-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keyboard_event_queue.md
Name: keyboard_event_queue

Overview:
- Sits between keyboard_controller (PS/2 byte receiver) and the CPU bus.
- Takes raw scancode bytes (set 2), folds the E0 (extended) and F0 (break) prefixes into single key events, and buffers those events in a first-word-fall-through FIFO that the CPU pops.
- Moves the byte stream from the ps2_clk domain into the system clock domain, and drops stale prefixes after a timeout.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- TIMEOUT, 100000, clk cycles a prefix state may wait for its next byte before it is discarded.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- kb_data  input  8  byte from keyboard_controller; stable while kb_valid is high.
- kb_valid  input  1  level from keyboard_controller (ps2_clk domain); rises once per received byte.
- ev_data  output  10  FIFO head: [9] break, [8] extended, [7:0] scancode.
- ev_valid  output  1  FIFO not empty.
- ev_ready  input  1  pop strobe; pops when ev_valid&&ev_ready at a clk edge.
- ev_count  output  $clog2(DEPTH)+1  entries held.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- clr_ovf  input  1  clears overflow (set wins if both happen in the same cycle).

Behaviour:
- Reset (async, rst_n=0): sync flops=0, FSM=IDLE, timeout counter=0, FIFO pointers=0, ev_valid=0, ev_count=0, overflow=0, ev_data=0. Reset mid-frame discards any pending prefix and all queued events.
- Sync: kb_valid passes through 2 flops (s1,s2) plus a prev flop. byte_strobe = s2&~prev. kb_data is captured on the byte_strobe edge; no data synchronizer is needed because the data is held.
- Latency: kb_valid first sampled 1 at edge N → strobe during the cycle after N+1 → FSM/FIFO update at edge N+2 → ev_valid=1 after N+2.
- FSM states: IDLE, EXT, BRK, EXT_BRK. On each strobe with byte b:
  - IDLE: E0→EXT; F0→BRK; else push {0,0,b}.
  - EXT: F0→EXT_BRK; E0→EXT (re-arm); else push {0,1,b}→IDLE.
  - BRK: E0→EXT (prefix error, restart); F0→BRK; else push {1,0,b}→IDLE.
  - EXT_BRK: E0→EXT; F0→EXT_BRK; else push {1,1,b}→IDLE.
  - All other bytes, including E1, AA, FA, are ordinary codes.
- Timeout: counter clears on each strobe and in IDLE. It increments while in a non-IDLE state. When it reaches TIMEOUT-1, the FSM→IDLE and the counter→0; no event is pushed.
- FIFO (first-word-fall-through): ev_data shows the head combinationally from storage.
  - Push when full and no pop: the event is dropped and overflow=1.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH. ev_count = writes - pops, range 0..DEPTH.
- kb_valid held high for many cycles produces exactly one strobe. The byte's rising edge must be separated from the previous one by ≥4 clk cycles; closer rising edges are not required to be captured.

Test Plan:
1. Byte 0x1C (A make) → after 3 edges ev_valid=1, ev_data=0x01C, ev_count=1; pop with ev_ready → ev_valid=0.
2. Bytes F0,1C → single event 0x21C; no event after F0 alone.
3. Bytes E0,F0,74 → 0x374; bytes E0,74 → 0x174; ev_count=2, popped in order 0x374 then 0x174.
4. DEPTH=8: push 9 make codes 0x10..0x18 with no pops → ev_count=8, overflow=1, head 0x010, 0x018 lost; clr_ovf → overflow=0. Then push while full with ev_ready=1 in the same cycle → count stays 8, overflow stays 0.
5. TIMEOUT=16: byte F0, wait 20 cycles, byte 1C → event 0x01C (make, not break). Bytes F0,E0,75 → 0x175.
6. Send E0; assert rst_n=0 mid-stream with 2 events queued → ev_valid=0, ev_count=0 immediately. After release, byte 0x1C → 0x01C.
